// File: rtl/exec_pkg.sv
// Opcode/function-code constants and byte-lane masks shared by the execute stage.
package exec_pkg;
   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_ADDI  = 6'd1;
   localparam logic [5:0] OP_LUI   = 6'd3;
   localparam logic [5:0] OP_ANDI  = 6'd4;
   localparam logic [5:0] OP_ORI   = 6'd5;
   localparam logic [5:0] OP_XORI  = 6'd6;
   localparam logic [5:0] OP_LW    = 6'd16;
   localparam logic [5:0] OP_LH    = 6'd18;
   localparam logic [5:0] OP_LB    = 6'd20;
   localparam logic [5:0] OP_SW    = 6'd24;
   localparam logic [5:0] OP_SH    = 6'd26;
   localparam logic [5:0] OP_SB    = 6'd28;
   localparam logic [5:0] OP_BEQ   = 6'd32;
   localparam logic [5:0] OP_BNE   = 6'd33;
   localparam logic [5:0] OP_BLT   = 6'd34;
   localparam logic [5:0] OP_BLE   = 6'd35;
   localparam logic [5:0] OP_J     = 6'd40;
   localparam logic [5:0] OP_JAL   = 6'd41;
   localparam logic [5:0] OP_JR    = 6'd42;

   localparam logic [4:0] FN_ADD = 5'd0;
   localparam logic [4:0] FN_SUB = 5'd2;
   localparam logic [4:0] FN_AND = 5'd8;
   localparam logic [4:0] FN_OR  = 5'd9;
   localparam logic [4:0] FN_XOR = 5'd10;
   localparam logic [4:0] FN_NOR = 5'd11;
   localparam logic [4:0] FN_SLL = 5'd16;
   localparam logic [4:0] FN_SRL = 5'd17;
   localparam logic [4:0] FN_SRA = 5'd18;
   localparam logic [4:0] FN_MUL = 5'd24;

   localparam logic [3:0] WREN_W = 4'b1111;
   localparam logic [3:0] WREN_H = 4'b0011;
   localparam logic [3:0] WREN_B = 4'b0001;
   localparam logic [4:0] REG_RA = 5'd31;
endpackage

// File: rtl/exec_stage_if.sv
// Decode->execute operand bundle and execute->write results.
// master = pipeline side driving operands, slave = the execute stage.
interface exec_stage_if;
   logic [31:0] pc;
   logic [5:0]  op;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [10:0] aux;
   logic [31:0] os;
   logic [31:0] ot;
   logic [31:0] imm_dpl;
   logic [31:0] result;
   logic [4:0]  wreg;
   logic [3:0]  wren;
   logic [31:0] dm_addr;

   modport master (output pc, op, rt, rd, aux, os, ot, imm_dpl,
                   input  result, wreg, wren, dm_addr);
   modport slave  (input  pc, op, rt, rd, aux, os, ot, imm_dpl,
                   output result, wreg, wren, dm_addr);
endinterface

// File: rtl/byte_lane_mem.sv
// One 8-bit byte lane of the data memory: sync write, async read,
// asynchronous reset clears every word.
module byte_lane_mem #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [7:0]    wdata_i,
   output logic [7:0]    rdata_o
);
   logic [7:0] mem_q [2**AW];

   // Reset wipes the whole lane and wins over a concurrent write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**AW; i++) mem_q[i] <= 8'h00;
      end else if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/exec_stage.sv
// Execute stage: combinational ALU/decode plus a 4-lane data memory.
// Optional macro EXEC_MUL_EN enables R-type function 24 (mul).
module exec_stage
   import exec_pkg::*;
#(
   parameter int DM_AW = 8
) (
   input  logic        clk,
   input  logic        rstd,
   exec_stage_if.slave bus
);
   logic [31:0] addr;
   logic [31:0] rdata;
   logic [31:0] result_d;
   logic [4:0]  wreg_d;
   logic [3:0]  wren_d;
   logic [31:0] zimm;
   logic [4:0]  shamt;

   assign addr  = bus.os + bus.imm_dpl;
   assign zimm  = {16'h0, bus.imm_dpl[15:0]};
   assign shamt = bus.aux[10:6];

   // Upper address bits wrap; aux[5] carries no meaning.
   logic unused_bits;
   assign unused_bits = ^{bus.aux[5], addr[31:DM_AW]};

   // Four byte lanes; each writes its slice of the store data.
   for (genvar i = 0; i < 4; i++) begin : g_lane
      byte_lane_mem #(.AW(DM_AW)) u_lane (
         .clk     (clk),
         .rst     (rstd),
         .we_i    (wren_d[i]),
         .addr_i  (addr[DM_AW-1:0]),
         .wdata_i (result_d[8*i+7:8*i]),
         .rdata_o (rdata[8*i+7:8*i])
      );
   end

   // Opcode decode: undefined ops fall through to a harmless no-op.
   always_comb begin
      result_d = 32'h0;
      wreg_d   = 5'd0;
      wren_d   = 4'b0000;
      case (bus.op)
         OP_RTYPE: begin
            wreg_d = bus.rd;
            case (bus.aux[4:0])
               FN_ADD: result_d = bus.os + bus.ot;
               FN_SUB: result_d = bus.os - bus.ot;
               FN_AND: result_d = bus.os & bus.ot;
               FN_OR:  result_d = bus.os | bus.ot;
               FN_XOR: result_d = bus.os ^ bus.ot;
               FN_NOR: result_d = ~(bus.os | bus.ot);
               FN_SLL: result_d = bus.ot << shamt;
               FN_SRL: result_d = bus.ot >> shamt;
               FN_SRA: result_d = $signed(bus.ot) >>> shamt;
`ifdef EXEC_MUL_EN
               FN_MUL: result_d = bus.os * bus.ot;
`else
`endif
               default: result_d = 32'h0;
            endcase
         end
         OP_ADDI: begin result_d = bus.os + bus.imm_dpl;       wreg_d = bus.rt; end
         OP_LUI:  begin result_d = {bus.imm_dpl[15:0], 16'h0}; wreg_d = bus.rt; end
         OP_ANDI: begin result_d = bus.os & zimm;              wreg_d = bus.rt; end
         OP_ORI:  begin result_d = bus.os | zimm;              wreg_d = bus.rt; end
         OP_XORI: begin result_d = bus.os ^ zimm;              wreg_d = bus.rt; end
         OP_LW:   begin result_d = rdata;                          wreg_d = bus.rt; end
         OP_LH:   begin result_d = {{16{rdata[15]}}, rdata[15:0]}; wreg_d = bus.rt; end
         OP_LB:   begin result_d = {{24{rdata[7]}}, rdata[7:0]};   wreg_d = bus.rt; end
         OP_SW:   begin result_d = bus.ot; wren_d = WREN_W; end
         OP_SH:   begin result_d = bus.ot; wren_d = WREN_H; end
         OP_SB:   begin result_d = bus.ot; wren_d = WREN_B; end
         OP_JAL:  begin result_d = bus.pc + 32'd1; wreg_d = REG_RA; end
         // Control flow is resolved by the PC unit; nothing to write back.
         OP_BEQ, OP_BNE, OP_BLT, OP_BLE, OP_J, OP_JR: begin
            result_d = 32'h0;
            wreg_d   = 5'd0;
         end
         default: ;
      endcase
   end

   assign bus.result  = result_d;
   assign bus.wreg    = wreg_d;
   assign bus.wren    = wren_d;
   assign bus.dm_addr = addr;
endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: table of ALU vectors, then memory sequences.
module tb_exec_stage;
   logic clk = 1'b0;
   logic rstd = 1'b1;
   int   errors = 0;
   int   checks = 0;

   exec_stage_if bus ();

   exec_stage #(.DM_AW(8)) dut (
      .clk  (clk),
      .rstd (rstd),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [10:0] aux;
      logic [31:0] os;
      logic [31:0] ot;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] exp_result;
      logic [4:0]  exp_wreg;
      logic [3:0]  exp_wren;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string n, input logic [5:0] op, input logic [10:0] aux,
                      input logic [31:0] os, input logic [31:0] ot, input logic [31:0] imm,
                      input logic [31:0] pc, input logic [31:0] r, input logic [4:0] w,
                      input logic [3:0] we);
      vec_t v;
      v.name = n; v.op = op; v.aux = aux; v.os = os; v.ot = ot; v.imm = imm; v.pc = pc;
      v.exp_result = r; v.exp_wreg = w; v.exp_wren = we;
      vecs.push_back(v);
   endtask

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic [31:0] os, input logic [31:0] ot,
                        input logic [31:0] imm);
      bus.op = op; bus.os = os; bus.ot = ot; bus.imm_dpl = imm;
      bus.aux = 11'd0; bus.pc = 32'd0;
   endtask

   // Advance past the next rising edge so any store lands, then settle.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.pc = 0; bus.op = 6'd63; bus.rt = 5'd5; bus.rd = 5'd3; bus.aux = 0;
      bus.os = 0; bus.ot = 0; bus.imm_dpl = 0;

      // rt=5, rd=3 throughout the table
      add("add",   6'd0, 11'd0,              32'd5, 32'd7, 0, 0, 32'd12,        5'd3, 4'b0);
      add("sub",   6'd0, 11'd2,              32'd5, 32'd7, 0, 0, 32'hFFFFFFFE,  5'd3, 4'b0);
      add("sra",   6'd0, {5'd4, 6'd18},      0, 32'h80000000, 0, 0, 32'hF8000000, 5'd3, 4'b0);
      add("srl",   6'd0, {5'd4, 6'd17},      0, 32'h80000000, 0, 0, 32'h08000000, 5'd3, 4'b0);
      add("sll",   6'd0, {5'd4, 6'd16},      0, 32'h0000000F, 0, 0, 32'h000000F0, 5'd3, 4'b0);
      add("and",   6'd0, 11'd8,  32'hF0F0, 32'hFF00, 0, 0, 32'h0000F000, 5'd3, 4'b0);
      add("or",    6'd0, 11'd9,  32'hF0F0, 32'hFF00, 0, 0, 32'h0000FFF0, 5'd3, 4'b0);
      add("xor",   6'd0, 11'd10, 32'hF0F0, 32'hFF00, 0, 0, 32'h00000FF0, 5'd3, 4'b0);
      add("nor",   6'd0, 11'd11, 32'hF0F0, 32'hFF00, 0, 0, 32'hFFFF000F, 5'd3, 4'b0);
      add("fn5",   6'd0, 11'd5,  32'd9, 32'd9, 0, 0, 32'd0, 5'd3, 4'b0);
`ifdef EXEC_MUL_EN
      add("mul",   6'd0, 11'd24, 32'd6, 32'd7, 0, 0, 32'd42, 5'd3, 4'b0);
`else
      add("mul",   6'd0, 11'd24, 32'd6, 32'd7, 0, 0, 32'd0,  5'd3, 4'b0);
`endif
      add("addi",  6'd1, 0, 32'd10, 0, 32'hFFFFFFFF, 0, 32'd9, 5'd5, 4'b0);
      add("lui",   6'd3, 0, 32'd77, 0, 32'h00001234, 0, 32'h12340000, 5'd5, 4'b0);
      add("andi",  6'd4, 0, 32'hFFFFFFFF, 0, 32'hFFFF8001, 0, 32'h00008001, 5'd5, 4'b0);
      add("ori",   6'd5, 0, 32'h12340000, 0, 32'hFFFF8000, 0, 32'h12348000, 5'd5, 4'b0);
      add("xori",  6'd6, 0, 32'hFFFFFFFF, 0, 32'hFFFF00FF, 0, 32'hFFFFFF00, 5'd5, 4'b0);
      add("jal",   6'd41, 0, 0, 0, 0, 32'd100, 32'd101, 5'd31, 4'b0);
      add("beq",   6'd32, 0, 32'd4, 32'd4, 32'd8, 32'd50, 32'd0, 5'd0, 4'b0);
      add("jr",    6'd42, 0, 32'd4, 32'd4, 32'd8, 32'd50, 32'd0, 5'd0, 4'b0);
      add("undef", 6'd63, 11'd0, 32'd5, 32'd7, 32'd1, 32'd50, 32'd0, 5'd0, 4'b0);

      // Memory is cleared while reset is held.
      #2;
      drive(6'd16, 32'h10, 0, 32'd4);
      #1;
      check("reset_lw", bus.result, 32'h0);
      tick;
      rstd = 1'b0;
      #2;

      for (int i = 0; i < vecs.size(); i++) begin
         bus.op = vecs[i].op; bus.aux = vecs[i].aux; bus.os = vecs[i].os;
         bus.ot = vecs[i].ot; bus.imm_dpl = vecs[i].imm; bus.pc = vecs[i].pc;
         #1;
         check({vecs[i].name, ".result"}, bus.result, vecs[i].exp_result);
         check({vecs[i].name, ".wreg"}, {27'd0, bus.wreg}, {27'd0, vecs[i].exp_wreg});
         check({vecs[i].name, ".wren"}, {28'd0, bus.wren}, {28'd0, vecs[i].exp_wren});
         #1;
      end

      // sw then lw at word 0x14
      drive(6'd24, 32'h10, 32'hDEADBEEF, 32'd4);
      #1;
      check("sw.dm_addr", bus.dm_addr, 32'h14);
      check("sw.result", bus.result, 32'hDEADBEEF);
      check("sw.wren", {28'd0, bus.wren}, 32'hF);
      check("sw.wreg", {27'd0, bus.wreg}, 32'd0);
      tick;
      drive(6'd16, 32'h10, 0, 32'd4);
      #1;
      check("lw.result", bus.result, 32'hDEADBEEF);
      check("lw.wreg", {27'd0, bus.wreg}, 32'd5);
      check("lw.wren", {28'd0, bus.wren}, 32'd0);

      // sb only touches lane 0
      drive(6'd28, 32'h10, 32'h000000F0, 32'd4);
      #1;
      check("sb.wren", {28'd0, bus.wren}, 32'h1);
      tick;
      drive(6'd16, 32'h10, 0, 32'd4);  #1; check("sb.lw", bus.result, 32'hDEADBEF0);
      drive(6'd20, 32'h10, 0, 32'd4);  #1; check("lb",    bus.result, 32'hFFFFFFF0);
      drive(6'd18, 32'h10, 0, 32'd4);  #1; check("lh",    bus.result, 32'hFFFFBEF0);

      // sh into a fresh word
      drive(6'd26, 32'h20, 32'hAAAA1234, 32'd0);
      #1;
      check("sh.wren", {28'd0, bus.wren}, 32'h3);
      tick;
      drive(6'd16, 32'h20, 0, 32'd0);  #1; check("sh.lw", bus.result, 32'h00001234);

      // address wraps modulo 256 words
      drive(6'd24, 32'h110, 32'hCAFEF00D, 32'd4);
      #1;
      check("wrap.dm_addr", bus.dm_addr, 32'h114);
      tick;
      drive(6'd16, 32'h10, 0, 32'd4);  #1; check("wrap.lw", bus.result, 32'hCAFEF00D);

      // reset mid-run, with a store held active across the edge
      drive(6'd24, 32'h20, 32'h55555555, 32'd0);
      rstd = 1'b1;
      tick;
      drive(6'd16, 32'h10, 0, 32'd4);
      #1;
      rstd = 1'b0;
      #1;
      check("rst.lw14", bus.result, 32'h0);
      drive(6'd16, 32'h20, 0, 32'd0);  #1; check("rst.lw20", bus.result, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
